// File: rtl/bram_arbiter_if.sv
// Signal bundle joining the CPU bus, the video fetcher and BRAM port A to the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
interface bram_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic [7:0]  vid_len;
  logic        vid_busy;
  logic        vid_valid;
  logic [7:0]  vid_data;
  logic        vid_done;
  logic        mem_cs;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output vid_req, vid_addr, vid_len,
    output mem_rdata,
    input  cpu_ack, cpu_rdata,
    input  vid_busy, vid_valid, vid_data, vid_done,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  vid_req, vid_addr, vid_len,
    input  mem_rdata,
    output cpu_ack, cpu_rdata,
    output vid_busy, vid_valid, vid_data, vid_done,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bram_arbiter.sv
// Shares one BRAM port between CPU byte accesses and video burst reads; the CPU is
// guaranteed a slot after at most MAX_VID_RUN consecutive video issues.
module bram_arbiter #(
  parameter int MAX_VID_RUN = 4
) (
  input  logic          clk,
  input  logic          rst,
  bram_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_CPU  = 2'd1;
  localparam logic [1:0] TAG_VID  = 2'd2;
  localparam logic [7:0] MAX_RUN  = 8'(MAX_VID_RUN);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] vaddr_q, vaddr_d;
  logic [8:0]  vrem_q, vrem_d;
  logic [7:0]  vrun_q, vrun_d;
  logic        cpu_out_q, cpu_out_d;
  logic [1:0]  tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d;
  logic        wr_p1_q, wr_p1_d, wr_p2_q, wr_p2_d;
  logic        mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic        vid_busy_q, vid_busy_d, vid_valid_q, vid_valid_d, vid_done_q, vid_done_d;
  logic [7:0]  vid_data_q, vid_data_d;
  logic        cpu_pend, cpu_issue, vid_issue;

  always_comb begin
    state_d     = state_q;
    vaddr_d     = vaddr_q;
    vrem_d      = vrem_q;
    vrun_d      = vrun_q;
    cpu_out_d   = cpu_out_q;
    tag_p1_d    = TAG_NONE;
    wr_p1_d     = 1'b0;
    tag_p2_d    = tag_p1_q;
    wr_p2_d     = wr_p1_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_busy_d  = vid_busy_q;
    vid_valid_d = 1'b0;
    vid_data_d  = vid_data_q;
    vid_done_d  = 1'b0;

    cpu_pend  = bus.cpu_req & ~cpu_out_q;
    cpu_issue = cpu_pend & ((state_q != ST_BURST) | (vrun_q >= MAX_RUN));
    vid_issue = ~cpu_issue & (state_q == ST_BURST);

    // vrun only measures video issues that keep a waiting CPU out
    if (!cpu_pend) vrun_d = 8'd0;

    // Stage 2 -> output: route the returning BRAM byte by its source tag
    if (tag_p2_q == TAG_CPU) begin
      cpu_ack_d = 1'b1;
      cpu_out_d = 1'b0;
      if (!wr_p2_q) cpu_rdata_d = bus.mem_rdata;
    end
    if (tag_p2_q == TAG_VID) begin
      vid_valid_d = 1'b1;
      vid_data_d  = bus.mem_rdata;
    end

    // Issue -> stage 1
    if (cpu_issue) begin
      mem_cs_d    = 1'b1;
      mem_we_d    = bus.cpu_we;
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
      cpu_out_d   = 1'b1;
      vrun_d      = 8'd0;
      tag_p1_d    = TAG_CPU;
      wr_p1_d     = bus.cpu_we;
    end else if (vid_issue) begin
      mem_cs_d   = 1'b1;
      mem_addr_d = vaddr_q;
      vaddr_d    = vaddr_q + 16'd1;
      vrem_d     = vrem_q - 9'd1;
      vrun_d     = cpu_pend ? sat_inc8(vrun_q) : 8'd0;
      tag_p1_d   = TAG_VID;
      if (vrem_q == 9'd1) state_d = ST_DRAIN;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.vid_req) begin
          vaddr_d    = bus.vid_addr;
          vrem_d     = (bus.vid_len == 8'd0) ? 9'd256 : {1'b0, bus.vid_len};
          vid_busy_d = 1'b1;
          state_d    = ST_BURST;
        end
      end
      ST_DRAIN: begin
        // No video issues happen here, so a VID tag with none behind it is the burst's last byte
        if ((tag_p2_q == TAG_VID) && (tag_p1_q != TAG_VID)) begin
          vid_done_d = 1'b1;
          vid_busy_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      vaddr_q     <= 16'd0;
      vrem_q      <= 9'd0;
      vrun_q      <= 8'd0;
      cpu_out_q   <= 1'b0;
      tag_p1_q    <= TAG_NONE;
      tag_p2_q    <= TAG_NONE;
      wr_p1_q     <= 1'b0;
      wr_p2_q     <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'd0;
      vid_busy_q  <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_data_q  <= 8'd0;
      vid_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      vaddr_q     <= vaddr_d;
      vrem_q      <= vrem_d;
      vrun_q      <= vrun_d;
      cpu_out_q   <= cpu_out_d;
      tag_p1_q    <= tag_p1_d;
      tag_p2_q    <= tag_p2_d;
      wr_p1_q     <= wr_p1_d;
      wr_p2_q     <= wr_p2_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_busy_q  <= vid_busy_d;
      vid_valid_q <= vid_valid_d;
      vid_data_q  <= vid_data_d;
      vid_done_q  <= vid_done_d;
    end
  end

  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.vid_busy  = vid_busy_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_data  = vid_data_q;
  assign bus.vid_done  = vid_done_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: BRAM model, scoreboard queues for returned bytes,
// and an issue log checked against the expected slot order.
`timescale 1ns/1ps
module tb_bram_arbiter;
  logic clk = 1'b0;
  logic rst;
  bram_arbiter_if bus ();

  bram_arbiter #(.MAX_VID_RUN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // BRAM model: registered read, pattern-filled on the first edge
  logic [7:0]  mem [0:65535];
  logic        mem_init_q = 1'b0;
  logic        pre_we;
  logic [15:0] pre_addr;
  logic [7:0]  pre_data;
  always @(posedge clk) begin
    if (!mem_init_q) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
      mem_init_q <= 1'b1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.mem_cs) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  exp_vid [$];
  logic [7:0]  exp_cpu [$];
  int unsigned iss_cyc [$];
  logic [15:0] iss_addr [$];
  int unsigned vv_cyc [$];
  int unsigned cs_cnt = 0, vv_cnt = 0, done_cnt = 0;

  always @(negedge clk) begin
    if (bus.mem_cs) begin
      cs_cnt++;
      iss_cyc.push_back(cyc);
      iss_addr.push_back(bus.mem_addr);
    end
    if (bus.vid_valid) begin
      vv_cnt++;
      vv_cyc.push_back(cyc);
      if (exp_vid.size() == 0) chk("vid_unexpected", 32'(bus.vid_valid), 32'd0);
      else chk("vid_data", 32'(bus.vid_data), 32'(exp_vid.pop_front()));
    end
    if (bus.cpu_ack) begin
      if (exp_cpu.size() == 0) chk("cpu_ack_unexpected", 32'(bus.cpu_ack), 32'd0);
      else chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_cpu.pop_front()));
    end
    if (bus.vid_done) done_cnt++;
  end

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic wait_ack(input int budget);
    int i = 0;
    while (!bus.cpu_ack && i < budget) begin @(negedge clk); i++; end
    chk("ack_timeout", 32'(bus.cpu_ack), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (!bus.vid_done && i < budget) begin @(negedge clk); i++; end
    chk("done_timeout", 32'(bus.vid_done), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cpu"}, {23'd0, bus.cpu_ack, bus.cpu_rdata}, 32'd0);
    chk({tag, "_vid"}, {21'd0, bus.vid_busy, bus.vid_valid, bus.vid_data, bus.vid_done}, 32'd0);
    chk({tag, "_mem"}, {6'd0, bus.mem_cs, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 32'd0);
  endtask

  logic [15:0] c_addr [10] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103, 16'h2000,
                               16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h2000};
  int unsigned c_off  [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e, n, done_cyc, base_cs, base_vv, base_done, bad;
    int acks, i;
    bit done_seen;
    rst = 1'b1;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_req = 1'b0; bus.vid_addr = '0; bus.vid_len = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // CPU write 0x5A to 0x1234 then read it back
    base_cs = cs_cnt;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'h5A;
    exp_cpu.push_back(8'h00);
    n = cyc + 1;
    @(negedge clk);
    chk("wr_mem_cs_we", {30'd0, bus.mem_cs, bus.mem_we}, 32'd3);
    chk("wr_mem_addr", 32'(bus.mem_addr), 32'h1234);
    chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h5A);
    wait_ack(8);
    chk("wr_ack_cycle", cyc, n + 2);
    bus.cpu_req = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0;
    exp_cpu.push_back(8'h5A);
    n = cyc + 1;
    @(negedge clk);
    chk("rd_mem_cs_we", {30'd0, bus.mem_cs, bus.mem_we}, 32'd2);
    wait_ack(8);
    chk("rd_ack_cycle", cyc, n + 2);
    chk("rd_data", 32'(bus.cpu_rdata), 32'h5A);
    bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("cpu_cs_count", cs_cnt - base_cs, 32'd2);
    chk("rd_data_hold", 32'(bus.cpu_rdata), 32'h5A);

    // Wrapping burst across 0xFFFF
    preload(16'hFFFE, 8'h11); preload(16'hFFFF, 8'h22);
    preload(16'h0000, 8'h33); preload(16'h0001, 8'h44);
    vv_cyc.delete();
    bus.vid_req = 1'b1; bus.vid_addr = 16'hFFFE; bus.vid_len = 8'd4;
    exp_vid.push_back(8'h11); exp_vid.push_back(8'h22);
    exp_vid.push_back(8'h33); exp_vid.push_back(8'h44);
    e = cyc + 1;
    @(negedge clk);
    bus.vid_req = 1'b0;
    chk("wrap_busy", 32'(bus.vid_busy), 32'd1);
    wait_done(30);
    chk("wrap_done_cycle", cyc, e + 6);
    @(negedge clk);
    chk("wrap_busy_low", 32'(bus.vid_busy), 32'd0);
    chk("wrap_valid_count", vv_cyc.size(), 32'd4);
    chk("wrap_first_valid", vv_cyc[0], e + 3);
    chk("wrap_last_valid", vv_cyc[3], e + 6);
    preload(16'hFFFE, pat(16'hFFFE)); preload(16'hFFFF, pat(16'hFFFF));
    preload(16'h0000, pat(16'h0000)); preload(16'h0001, pat(16'h0001));

    // CPU read held during an 8-byte burst: V,V,V,V,C,V,V,V,V then C in DRAIN
    iss_cyc.delete(); iss_addr.delete(); vv_cyc.delete();
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0100; bus.vid_len = 8'd8;
    for (int k = 0; k < 8; k++) exp_vid.push_back(pat(16'h0100 + 16'(k)));
    e = cyc + 1;
    @(negedge clk);
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h2000;
    exp_cpu.push_back(pat(16'h2000)); exp_cpu.push_back(pat(16'h2000));
    acks = 0; i = 0; done_seen = 1'b0; done_cyc = 0;
    while ((acks < 2 || !done_seen) && i < 40) begin
      @(negedge clk);
      i++;
      if (bus.cpu_ack) begin
        acks++;
        if (acks == 2) bus.cpu_req = 1'b0;
      end
      if (bus.vid_done) begin done_seen = 1'b1; done_cyc = cyc; end
    end
    chk("mix_acks", 32'(acks), 32'd2);
    chk("mix_done_cycle", done_cyc, e + 11);
    @(negedge clk);
    chk("mix_issue_count", iss_addr.size(), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk("mix_issue_addr", 32'(iss_addr[k]), 32'(c_addr[k]));
      chk("mix_issue_cycle", iss_cyc[k], e + c_off[k]);
    end
    chk("mix_valid_count", vv_cyc.size(), 32'd8);
    chk("mix_valid_pre_gap", vv_cyc[3], e + 6);
    chk("mix_valid_post_gap", vv_cyc[4], e + 8);

    // 256-byte burst wrapping 64K, with vid_req pulses while busy
    iss_cyc.delete(); iss_addr.delete(); vv_cyc.delete();
    base_done = done_cnt;
    bus.vid_req = 1'b1; bus.vid_addr = 16'hFF80; bus.vid_len = 8'd0;
    for (int k = 0; k < 256; k++) exp_vid.push_back(pat(16'hFF80 + 16'(k)));
    e = cyc + 1;
    @(negedge clk);
    bus.vid_req = 1'b0;
    repeat (4) @(negedge clk);
    bus.vid_req = 1'b1; bus.vid_addr = 16'h4000; bus.vid_len = 8'd3;
    @(negedge clk);
    bus.vid_req = 1'b0;
    repeat (100) @(negedge clk);
    bus.vid_req = 1'b1;
    @(negedge clk);
    bus.vid_req = 1'b0;
    wait_done(400);
    chk("long_done_cycle", cyc, e + 258);
    @(negedge clk);
    chk("long_valid_count", vv_cyc.size(), 32'd256);
    chk("long_issue_count", iss_addr.size(), 32'd256);
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (iss_addr[k] !== 16'hFF80 + 16'(k)) bad++;
    chk("long_issue_addrs", bad, 32'd0);
    chk("long_done_count", done_cnt - base_done, 32'd1);
    repeat (3) @(negedge clk);
    chk("long_busy_low", 32'(bus.vid_busy), 32'd0);

    // Reset sampled at E+2 of an 8-byte burst discards everything in flight
    bus.vid_req = 1'b1; bus.vid_addr = 16'h0300; bus.vid_len = 8'd8;
    @(negedge clk);
    bus.vid_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_outputs_zero("midrst");
    base_cs = cs_cnt; base_vv = vv_cnt; base_done = done_cnt;
    repeat (20) @(negedge clk);
    chk("midrst_cs", cs_cnt - base_cs, 32'd0);
    chk("midrst_valid", vv_cnt - base_vv, 32'd0);
    chk("midrst_done", done_cnt - base_done, 32'd0);

    chk("vid_queue_empty", exp_vid.size(), 32'd0);
    chk("cpu_queue_empty", exp_cpu.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Single-port access scheduler for the 64 KB lower-RAM block. It shares one BRAM port between two requesters: CPU single-byte reads/writes and video burst reads. Video bursts are streamed at one byte per cycle, and CPU accesses are guaranteed a slot at least every `MAX_VID_RUN` video reads. It sits between the CPU bus/video fetcher and BRAM port A.

## Interface
- `MAX_VID_RUN`, default 4: maximum consecutive video issues while a CPU access is pending; range 1–255.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held high, with stable inputs, until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  16  CPU byte address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_ack`  out  1  one-cycle pulse: access complete; `cpu_rdata` valid for reads.
- `cpu_rdata`  out  8  CPU read data; holds its value until the next CPU read ack.
- `vid_req`  in  1  burst start; sampled only when `vid_busy` = 0.
- `vid_addr`  in  16  burst start address.
- `vid_len`  in  8  burst length in bytes; 0 means 256.
- `vid_busy`  out  1  burst accepted and not yet finished.
- `vid_valid`  out  1  one-cycle pulse per returned burst byte.
- `vid_data`  out  8  burst byte; valid while `vid_valid` = 1.
- `vid_done`  out  1  pulse coincident with the last `vid_valid` of a burst.
- `mem_cs`  out  1  BRAM chip select; high for exactly one cycle per access.
- `mem_we`  out  1  BRAM write enable.
- `mem_addr`  out  16  BRAM address.
- `mem_wdata`  out  8  BRAM write data.
- `mem_rdata`  in  8  BRAM read data; valid the cycle after the BRAM samples a read.

## Operation
- Burst FSM states:
  - IDLE: `vid_req` = 1 at an edge latches `vid_addr` into `vaddr` and `vid_len` into `vrem` (0→256). Sets `vid_busy`, moves to BURST.
  - BURST: issues video reads. When the issue leaves `vrem` = 0, moves to DRAIN.
  - DRAIN: waits for the last video byte to return. At that edge it pulses `vid_done`, clears `vid_busy`, and returns to IDLE.
- Issue slot, one per edge, evaluated in priority order:
  1. CPU issue when `cpu_pend` = `cpu_req & ~cpu_out` and either the FSM is not in BURST or `vrun` ≥ `MAX_VID_RUN`.
  2. Otherwise, video issue when the FSM is in BURST.
  3. Otherwise, no issue: `mem_cs` = 0.
- CPU issue:
  - Registers `mem_cs`=1, `mem_we`=`cpu_we`, `mem_addr`, `mem_wdata`.
  - Sets `cpu_out`; clears `vrun`.
- Video issue:
  - Registers `mem_cs`=1, `mem_we`=0, `mem_addr`=`vaddr`.
  - `vaddr` += 1, wrapping 0xFFFF→0x0000. `vrem` −= 1.
  - `vrun` += 1, saturating at 255.
  - `vrun` clears when `cpu_pend` = 0, so it counts only issues that starve the CPU.
- A 2-stage source tag pipeline (NONE/CPU/VID) follows each issue. A tag leaving stage 2 routes `mem_rdata`:
  - CPU tag: `cpu_rdata` ← data (reads only), `cpu_ack` = 1, `cpu_out` cleared.
  - VID tag: `vid_data` ← data, `vid_valid` = 1.
- A CPU write is acked with the same latency as a read; `cpu_rdata` is unchanged.
- `vid_req` is ignored while `vid_busy` = 1.
- The IDLE→BURST transition and a CPU issue occur on the same edge when both are requested.
- A CPU request arriving during DRAIN issues immediately.

## Timing
- Reset: every output is 0, FSM = IDLE, `vrun`/`vrem`/`vaddr` = 0, tags = NONE, `cpu_out` = 0. In-flight accesses are discarded: no ack, valid or done follows.
- CPU: `cpu_req` sampled at edge N (slot won) → `mem_*` valid after N → BRAM samples at N+1 → `cpu_ack`/`cpu_rdata` registered at N+2.
- CPU with `cpu_req` held continuously: issues at N, N+3, N+6, …
- Video: `vid_req` at edge E → first issue at E+1 → first `vid_valid` at E+3.
- Uncontended burst of L bytes: `vid_valid` pulses at E+3 … E+L+2. `vid_done` pulses and `vid_busy` falls at E+L+2. The next `vid_req` is accepted at E+L+3.
- A CPU slot inserted mid-burst delays all later video bytes by one cycle. `vid_valid` then has a one-cycle gap.

## Test plan
- Reset mid-burst: assert `rst` at E+2 of a length-8 burst → all outputs 0 next cycle; no further `vid_valid`, `vid_done` or `mem_cs`.
- CPU write 0x5A to 0x1234, then read of 0x1234 → write ack at N+2; read `cpu_rdata` = 0x5A two edges after its issue. `mem_cs` pulses once per access.
- Burst `vid_addr`=0xFFFE, `vid_len`=4, preloaded 0xFFFE=0x11, 0xFFFF=0x22, 0x0000=0x33, 0x0001=0x44 → `vid_data` 11,22,33,44 on consecutive cycles E+3…E+6. `vid_done` at E+6.
- `MAX_VID_RUN`=4, burst length 8 at 0x0100, `cpu_req` read held from E → issue order V,V,V,V,C,V,V,V,V (CPU wins from E+5). Next CPU issue no earlier than 3 cycles later. All 8 video bytes in order. `vid_done` at E+11.
- `vid_len`=0 → exactly 256 `vid_valid` pulses, addresses wrap mod 64 K, one `vid_done`.
- `vid_req` pulsed while `vid_busy`=1 → ignored; burst count and addresses unchanged.
